// File: rtl/add_share_arb_pkg.sv
// Shared definitions for the add_share_arb slice.
//   ADD_WIDTH / ADD_NREQ : default operand width and requester count.
//   pick_t               : result of a round-robin scan (found flag + index).
//   rr_pick()            : round-robin scan over up to 8 requesters, starting
//                          at ptr and wrapping modulo nreq.
package add_share_arb_pkg;

    localparam int ADD_WIDTH = 32;
    localparam int ADD_NREQ  = 4;
    localparam int MAX_NREQ  = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Requests and pointer are zero-extended to MAX_NREQ by the caller;
    // nreq bounds the scan so the wrap happens at the real requester count.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                      input logic [2:0]          ptr,
                                      input int unsigned         nreq);
        pick_t       r;
        int unsigned j;
        r = '0;
        j = 0;
        for (int unsigned k = 0; k < MAX_NREQ; k++) begin
            if (k < nreq && !r.found) begin
                j = (int'(ptr) + k) % nreq;
                if (valid[j]) begin
                    r.found = 1'b1;
                    r.idx   = j[2:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/add_share_arb_picker.sv
// rr_picker: purely combinational round-robin grant generator.
//   valid      in  NREQ  candidate requests (already qualified by the caller)
//   ptr        in  IDW   highest-priority requester index
//   gnt_onehot out NREQ  one-hot grant
//   gnt_idx    out IDW   index of the granted requester
//   any        out 1     a grant was issued
module rr_picker
    import add_share_arb_pkg::*;
#(
    parameter  int NREQ = ADD_NREQ,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    logic [MAX_NREQ-1:0] vpad;
    logic [2:0]          ppad;
    pick_t               p;

    always_comb begin
        vpad            = '0;
        vpad[NREQ-1:0]  = valid;
        ppad            = '0;
        ppad[IDW-1:0]   = ptr;
        p               = rr_pick(vpad, ppad, NREQ);
    end

    assign any     = p.found;
    assign gnt_idx = p.idx[IDW-1:0];

    always_comb begin
        gnt_onehot = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            gnt_onehot[i] = p.found && (p.idx == 3'(i));
        end
    end

endmodule

// File: rtl/add_share_arb.sv
// add_share_arb: round-robin sharing of one external WIDTH-bit adder among
// NREQ requesters, with a single registered response slot.
//   clk, rst           clock / async active-high reset
//   req_valid/req_a/b  per-requester request and flattened operands
//   req_ready          one-hot grant (accept = valid && ready)
//   add_a/add_b        operands to the shared adder, add_sum its result
//   rsp_valid/ready    response slot handshake
//   rsp_id/data/ovf    owner, truncated sum and signed-overflow flag
module add_share_arb
    import add_share_arb_pkg::*;
#(
    parameter  int NREQ  = ADD_NREQ,
    parameter  int WIDTH = ADD_WIDTH,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    input  logic [WIDTH-1:0]      add_sum,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_ovf
);

    logic [IDW-1:0]  ptr;
    logic            slot_free;
    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] gnt_onehot;
    logic [IDW-1:0]  gnt_idx;
    logic            any;
    logic [IDW-1:0]  sel;
    logic            ovf;

    assign slot_free = !rsp_valid || rsp_ready;
    // Gating candidates (not the grant) keeps req_ready, any and the
    // register updates consistent, including the all-zero grant during reset.
    assign cand      = (slot_free && !rst) ? req_valid : '0;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .valid      (cand),
        .ptr        (ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    assign req_ready = gnt_onehot;
    assign sel       = any ? gnt_idx : ptr;

    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (sel == IDW'(i)) begin
                add_a = req_a[i*WIDTH +: WIDTH];
                add_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ovf = (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                 (add_sum[WIDTH-1] != add_a[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_ovf   <= 1'b0;
            ptr       <= '0;
        end else if (any) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_idx;
            rsp_data  <= add_sum;
            rsp_ovf   <= ovf;
            ptr       <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
